uart_tx_serializer: RTL and testbench

- Transmit stage directly downstream of the UART TX FIFO.
- Pops bytes from the FIFO and serialises each one onto the tx line as an 8N1/8E1/8O1/8N2 frame, LSB first.
- Baud timing comes from an internal divide-by-CLKS_PER_BIT counter.
- Back-to-back frames are sent with no idle gap while the FIFO holds data.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 24 ++
 rtl/uart_tx_serializer.sv | 140 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, data width and the
// parity helper that the receiver also uses.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity is the XOR of the data bits; odd parity is its complement.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Divide-by-CLKS_PER_BIT counter; tick marks the last cycle of each bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || clear)     cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from a first-word-fall-through FIFO and
// sends 8-bit frames LSB first with optional parity and one or two stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_rd,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          ODD       = 1'(PARITY_ODD);

    uart_state_e          state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic                 stop_idx, stop_idx_n;
    logic                 par, par_n;
    logic                 tx_n;
    logic                 pop, done;
    logic                 tick;

    // The counter restarts on every state entry and is held clear while idle.
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .CLK   (CLK),
        .RST   (RST),
        .clear ((state == IDLE) || (state_n != state)),
        .tick  (tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par      <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_idx  <= bit_idx_n;
            stop_idx <= stop_idx_n;
            par      <= par_n;
            tx       <= tx_n;
        end
    end

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        par_n      = par;
        pop        = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_data;
                    par_n   = parity_bit(fifo_data, ODD);
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = {1'b0, shift[DATA_BITS-1:1]};
                    if (bit_idx == LAST_BIT) begin
                        bit_idx_n  = '0;
                        stop_idx_n = 1'b0;
                        state_n    = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    stop_idx_n = 1'b0;
                    state_n    = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_idx == LAST_STOP) begin
                        done = 1'b1;
                        // Chain straight into the next frame when data is waiting.
                        if (tx_en && !fifo_empty) begin
                            pop     = 1'b1;
                            shift_n = fifo_data;
                            par_n   = parity_bit(fifo_data, ODD);
                            state_n = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        stop_idx_n = stop_idx + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line level for the state being entered, so tx changes on the same edge.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

    assign fifo_rd    = pop && !RST;
    assign frame_done = done && !RST;
    assign busy       = !RST && ((state != IDLE) || pop);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: three framing variants share one
// byte stream; each has a per-cycle expected-line queue filled at every pop.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    typedef struct packed {
        logic lvl;
        logic last;
    } ent_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic tx_en = 1'b0;
    bit   chk_en = 1'b0;

    logic [7:0] mem [0:4095];
    int total = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[total] = b;
        total++;
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int PE = (g == 0) ? 0 : 1;
        localparam int OD = (g == 2) ? 1 : 0;
        localparam int SB = (g == 2) ? 2 : 1;
        localparam int NB = 1 + 8 + PE + SB;

        logic       fifo_empty, fifo_rd, tx, busy, frame_done;
        logic [7:0] fifo_data;
        int         rp = 0;

        assign fifo_empty = (rp >= total);
        assign fifo_data  = mem[rp];

        uart_tx_serializer #(
            .CLKS_PER_BIT(CPB), .PARITY_EN(PE), .PARITY_ODD(OD), .STOP_BITS(SB)
        ) dut (
            .CLK        (CLK),
            .RST        (RST),
            .tx_en      (tx_en),
            .fifo_empty (fifo_empty),
            .fifo_data  (fifo_data),
            .fifo_rd    (fifo_rd),
            .tx         (tx),
            .busy       (busy),
            .frame_done (frame_done)
        );

        always @(posedge CLK) if (fifo_rd) rp <= rp + 1;

        initial begin : mon
            ent_t       q[$];
            ent_t       e;
            bit         had;
            bit         pop_x;
            logic [7:0] b;
            logic       bv;
            forever begin
                @(negedge CLK);
                if (chk_en) begin
                    had = (q.size() > 0);
                    if (had) e = q.pop_front();
                    else     e = '{lvl: 1'b1, last: 1'b0};
                    check($sformatf("u%0d.tx", g), 32'(tx), 32'(e.lvl));
                    if (RST) begin
                        check($sformatf("u%0d.fifo_rd_in_rst", g), 32'(fifo_rd), 32'd0);
                        q.delete();
                    end else begin
                        pop_x = tx_en && (rp < total) && (!had || e.last);
                        check($sformatf("u%0d.fifo_rd", g), 32'(fifo_rd), 32'(pop_x));
                        check($sformatf("u%0d.frame_done", g), 32'(frame_done), 32'(had && e.last));
                        check($sformatf("u%0d.busy", g), 32'(busy), 32'(had || pop_x));
                        if (pop_x) begin
                            b = mem[rp];
                            for (int k = 0; k < NB; k++) begin
                                if (k == 0)              bv = 1'b0;
                                else if (k <= 8)         bv = b[k-1];
                                else if (PE != 0 && k == 9)
                                    bv = (($countones(b) + OD) % 2) == 1;
                                else                     bv = 1'b1;
                                for (int c = 0; c < CPB; c++)
                                    q.push_back('{lvl: bv, last: (k == NB - 1) && (c == CPB - 1)});
                            end
                        end
                    end
                end
            end
        end
    end

    function automatic bit drained();
        return g_inst[0].rp == total && g_inst[1].rp == total && g_inst[2].rp == total;
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        step(5);
        RST = 1'b0;
        tx_en = 1'b1;
        chk_en = 1'b1;
        step(20);

        push(8'h55);                   step(60);
        push(8'hA3); push(8'h0F);      step(120);
        push(8'h07);                   step(60);

        tx_en = 1'b0; push(8'h3C);     step(100);
        tx_en = 1'b1;                  step(60);

        push(8'hC3); push(8'h96);      step(15);
        RST = 1'b1;                    step(1);
        RST = 1'b0;                    step(120);

        push(8'h81); push(8'h7E);      step(10);
        tx_en = 1'b0;                  step(80);
        tx_en = 1'b1;                  step(60);

        step(1000);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) push(8'($urandom));
            if ($urandom_range(0, 399) == 0) tx_en = ~tx_en;
            RST = ($urandom_range(0, 1499) == 0);
            step(1);
        end
        RST = 1'b0;
        tx_en = 1'b1;
        for (int i = 0; i < 6000 && !drained(); i++) step(1);
        step(60);
        check("u0.drain", 32'(g_inst[0].rp), 32'(total));
        check("u1.drain", 32'(g_inst[1].rp), 32'(total));
        check("u2.drain", 32'(g_inst[2].rp), 32'(total));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
